// File: rtl/pipe_ctrl.sv
// Stage-sequencing controller for the 5-stage LC-3b pipeline: register loads,
// stage valid bits, hazard bubbles, branch squash with deferred redirect, stall counter.
module pipe_ctrl #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             imem_resp,
   input  logic             dmem_resp,
   input  logic             mem_dreq,
   input  logic             mem_br_taken,
   input  logic [15:0]      mem_br_target,
   input  logic             ex_mem_read,
   input  logic [2:0]       ex_dest,
   input  logic [2:0]       id_src1,
   input  logic [2:0]       id_src2,
   input  logic             id_use_src1,
   input  logic             id_use_src2,
   output logic             imem_read,
   output logic             load_pc,
   output logic [1:0]       pc_sel,
   output logic [15:0]      redirect_pc,
   output logic             load_if_id,
   output logic             load_id_ex,
   output logic             load_ex_mem,
   output logic             load_mem_wb,
   output logic             v_id,
   output logic             v_ex,
   output logic             v_mem,
   output logic             v_wb,
   output logic [CNT_W-1:0] stall_count
);

   localparam logic [0:0] ST_RUN  = 1'b0;
   localparam logic [0:0] ST_WAIT = 1'b1;

   logic [0:0]       state_r, state_nxt_s;
   logic [15:0]      redirect_pc_r, redirect_nxt_s;
   logic             v_id_r, v_ex_r, v_mem_r, v_wb_r;
   logic             v_id_nxt_s, v_ex_nxt_s, v_mem_nxt_s, v_wb_nxt_s;
   logic [CNT_W-1:0] stall_count_r;
   logic             src_match_s, dstall_s, flush_s, hazard_s;

   assign src_match_s = (id_use_src1 & (id_src1 == ex_dest)) |
                        (id_use_src2 & (id_src2 == ex_dest));
   assign dstall_s    = v_mem_r & mem_dreq & ~dmem_resp;
   assign flush_s     = v_mem_r & mem_br_taken;
   assign hazard_s    = v_id_r & v_ex_r & ex_mem_read & src_match_s;

   // Per-cycle control decode: D-miss freeze beats squash beats load-use bubble.
   always_comb begin
      load_pc        = 1'b0;
      pc_sel         = 2'b00;
      load_if_id     = 1'b0;
      load_id_ex     = 1'b0;
      load_ex_mem    = 1'b0;
      load_mem_wb    = 1'b0;
      state_nxt_s    = state_r;
      redirect_nxt_s = redirect_pc_r;
      v_id_nxt_s     = v_id_r;
      v_ex_nxt_s     = v_ex_r;
      v_mem_nxt_s    = v_mem_r;
      v_wb_nxt_s     = v_wb_r;
      if (dstall_s) begin
         state_nxt_s = state_r;
      end else if (flush_s) begin
         load_if_id  = 1'b1;
         load_id_ex  = 1'b1;
         load_ex_mem = 1'b1;
         load_mem_wb = 1'b1;
         v_id_nxt_s  = 1'b0;
         v_ex_nxt_s  = 1'b0;
         v_mem_nxt_s = 1'b0;
         v_wb_nxt_s  = 1'b1;
         if (state_r == ST_RUN) begin
            if (imem_resp) begin
               load_pc = 1'b1;
               pc_sel  = 2'b01;
            end else begin
               // PC must not move under a pending fetch; park the target.
               redirect_nxt_s = mem_br_target;
               state_nxt_s    = ST_WAIT;
            end
         end else begin
            state_nxt_s = state_r;
         end
      end else if (hazard_s) begin
         load_id_ex  = 1'b1;
         load_ex_mem = 1'b1;
         load_mem_wb = 1'b1;
         v_ex_nxt_s  = 1'b0;
         v_mem_nxt_s = v_ex_r;
         v_wb_nxt_s  = v_mem_r;
      end else begin
         load_if_id  = 1'b1;
         load_id_ex  = 1'b1;
         load_ex_mem = 1'b1;
         load_mem_wb = 1'b1;
         v_ex_nxt_s  = v_id_r;
         v_mem_nxt_s = v_ex_r;
         v_wb_nxt_s  = v_mem_r;
         case (state_r)
            ST_RUN: begin
               if (imem_resp) begin
                  load_pc    = 1'b1;
                  pc_sel     = 2'b00;
                  v_id_nxt_s = 1'b1;
               end else begin
                  v_id_nxt_s = 1'b0;
               end
            end
            ST_WAIT: begin
               // Returning word is wrong-path; drop it and apply the parked target.
               v_id_nxt_s = 1'b0;
               if (imem_resp) begin
                  load_pc     = 1'b1;
                  pc_sel      = 2'b10;
                  state_nxt_s = ST_RUN;
               end else begin
                  state_nxt_s = ST_WAIT;
               end
            end
            default: begin
               v_id_nxt_s  = 1'b0;
               state_nxt_s = ST_RUN;
            end
         endcase
      end
   end

   // State, valid bits, redirect latch and saturating stall counter.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r       <= ST_RUN;
         redirect_pc_r <= 16'h0000;
         v_id_r        <= 1'b0;
         v_ex_r        <= 1'b0;
         v_mem_r       <= 1'b0;
         v_wb_r        <= 1'b0;
         stall_count_r <= {CNT_W{1'b0}};
      end else begin
         state_r       <= state_nxt_s;
         redirect_pc_r <= redirect_nxt_s;
         v_id_r        <= v_id_nxt_s;
         v_ex_r        <= v_ex_nxt_s;
         v_mem_r       <= v_mem_nxt_s;
         v_wb_r        <= v_wb_nxt_s;
         if (!load_pc && (stall_count_r != {CNT_W{1'b1}})) begin
            stall_count_r <= stall_count_r + {{(CNT_W-1){1'b0}}, 1'b1};
         end else begin
            stall_count_r <= stall_count_r;
         end
      end
   end

   assign imem_read   = ~reset;
   assign redirect_pc = redirect_pc_r;
   assign v_id        = v_id_r;
   assign v_ex        = v_ex_r;
   assign v_mem       = v_mem_r;
   assign v_wb        = v_wb_r;
   assign stall_count = stall_count_r;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: directed vector table for the multi-cycle corner cases,
// then randomized traffic checked against a stage-array reference model.
module tb_pipe_ctrl;

   localparam int CW = 4;

   logic          clk = 1'b0;
   logic          reset, imem_resp, dmem_resp, mem_dreq, mem_br_taken;
   logic [15:0]   mem_br_target;
   logic          ex_mem_read, id_use_src1, id_use_src2;
   logic [2:0]    ex_dest, id_src1, id_src2;
   logic          imem_read, load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb;
   logic [1:0]    pc_sel;
   logic [15:0]   redirect_pc;
   logic          v_id, v_ex, v_mem, v_wb;
   logic [CW-1:0] stall_count;

   int checks = 0;
   int errors = 0;

   pipe_ctrl #(.CNT_W(CW)) dut (
      .clk(clk), .reset(reset), .imem_resp(imem_resp), .dmem_resp(dmem_resp),
      .mem_dreq(mem_dreq), .mem_br_taken(mem_br_taken), .mem_br_target(mem_br_target),
      .ex_mem_read(ex_mem_read), .ex_dest(ex_dest), .id_src1(id_src1), .id_src2(id_src2),
      .id_use_src1(id_use_src1), .id_use_src2(id_use_src2), .imem_read(imem_read),
      .load_pc(load_pc), .pc_sel(pc_sel), .redirect_pc(redirect_pc),
      .load_if_id(load_if_id), .load_id_ex(load_id_ex), .load_ex_mem(load_ex_mem),
      .load_mem_wb(load_mem_wb), .v_id(v_id), .v_ex(v_ex), .v_mem(v_mem), .v_wb(v_wb),
      .stall_count(stall_count)
   );

   always #5 clk = ~clk;

   // loads packed {if_id,id_ex,ex_mem,mem_wb}; v packed {id,ex,mem,wb}
   typedef struct {
      logic        rst, iresp, dreq, dresp, br, exrd, u1, u2;
      logic [15:0] tgt;
      logic [2:0]  dest, s1, s2;
      logic        chk_comb;
      logic        lpc;
      logic [1:0]  sel;
      logic [3:0]  ld;
      logic [3:0]  v;
      logic [15:0] rd;
      int          cnt;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t mk(input logic rst, iresp, dreq, dresp, br,
                               input logic [15:0] tgt, input logic haz, chk, lpc,
                               input logic [1:0] sel, input logic [3:0] ld, v,
                               input logic [15:0] rd, input int cnt);
      vec_t t;
      t.rst = rst; t.iresp = iresp; t.dreq = dreq; t.dresp = dresp; t.br = br;
      t.tgt = tgt; t.exrd = haz; t.dest = haz ? 3'd1 : 3'd0; t.u1 = haz;
      t.s1 = haz ? 3'd1 : 3'd0; t.u2 = 1'b0; t.s2 = 3'd5;
      t.chk_comb = chk; t.lpc = lpc; t.sel = sel; t.ld = ld; t.v = v; t.rd = rd; t.cnt = cnt;
      return t;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic apply(input vec_t t, input string tag);
      @(negedge clk);
      reset = t.rst; imem_resp = t.iresp; mem_dreq = t.dreq; dmem_resp = t.dresp;
      mem_br_taken = t.br; mem_br_target = t.tgt; ex_mem_read = t.exrd; ex_dest = t.dest;
      id_src1 = t.s1; id_src2 = t.s2; id_use_src1 = t.u1; id_use_src2 = t.u2;
      #1;
      chk({tag, " imem_read"}, {31'd0, imem_read}, {31'd0, ~t.rst});
      if (t.chk_comb) begin
         chk({tag, " load_pc"}, {31'd0, load_pc}, {31'd0, t.lpc});
         chk({tag, " pc_sel"}, {30'd0, pc_sel}, {30'd0, t.sel});
         chk({tag, " loads"}, {28'd0, load_if_id, load_id_ex, load_ex_mem, load_mem_wb},
             {28'd0, t.ld});
      end
      @(posedge clk);
      #1;
      chk({tag, " valid"}, {28'd0, v_id, v_ex, v_mem, v_wb}, {28'd0, t.v});
      chk({tag, " redirect_pc"}, {16'd0, redirect_pc}, {16'd0, t.rd});
      chk({tag, " stall_count"}, {28'd0, stall_count}, t.cnt);
   endtask

   // reference model state: mv bit3=ID .. bit0=WB
   logic [3:0]  mv;
   logic        m_wait;
   logic [15:0] m_redir;
   int          m_cnt;

   initial begin
      vec_t r;
      logic dst, fl, hz, match;
      // reset, fill
      tbl.push_back(mk(1,0,0,0,0,16'h0,0,0, 0,2'b00,4'h0, 4'b0000,16'h0,0));
      tbl.push_back(mk(1,0,0,0,0,16'h0,0,0, 0,2'b00,4'h0, 4'b0000,16'h0,0));
      tbl.push_back(mk(0,1,0,0,0,16'h0,0,1, 1,2'b00,4'hF, 4'b1000,16'h0,0));
      tbl.push_back(mk(0,1,0,0,0,16'h0,0,1, 1,2'b00,4'hF, 4'b1100,16'h0,0));
      tbl.push_back(mk(0,1,0,0,0,16'h0,0,1, 1,2'b00,4'hF, 4'b1110,16'h0,0));
      tbl.push_back(mk(0,1,0,0,0,16'h0,0,1, 1,2'b00,4'hF, 4'b1111,16'h0,0));
      tbl.push_back(mk(0,1,0,0,0,16'h0,0,1, 1,2'b00,4'hF, 4'b1111,16'h0,0));
      // load-use bubble, then recovery
      tbl.push_back(mk(0,1,0,0,0,16'h0,1,1, 0,2'b00,4'b0111, 4'b1011,16'h0,1));
      tbl.push_back(mk(0,1,0,0,0,16'h0,0,1, 1,2'b00,4'hF, 4'b1101,16'h0,1));
      tbl.push_back(mk(0,1,0,0,0,16'h0,0,1, 1,2'b00,4'hF, 4'b1110,16'h0,1));
      // D-cache miss freeze for three cycles
      tbl.push_back(mk(0,1,1,0,0,16'h0,0,1, 0,2'b00,4'h0, 4'b1110,16'h0,2));
      tbl.push_back(mk(0,1,1,0,0,16'h0,0,1, 0,2'b00,4'h0, 4'b1110,16'h0,3));
      tbl.push_back(mk(0,1,1,0,0,16'h0,0,1, 0,2'b00,4'h0, 4'b1110,16'h0,4));
      tbl.push_back(mk(0,1,1,1,0,16'h0,0,1, 1,2'b00,4'hF, 4'b1111,16'h0,4));
      // taken branch with fetch returning
      tbl.push_back(mk(0,1,0,0,1,16'h3000,0,1, 1,2'b01,4'hF, 4'b0001,16'h0,4));
      tbl.push_back(mk(0,1,0,0,0,16'h0,0,1, 1,2'b00,4'hF, 4'b1000,16'h0,4));
      tbl.push_back(mk(0,1,0,0,0,16'h0,0,1, 1,2'b00,4'hF, 4'b1100,16'h0,4));
      tbl.push_back(mk(0,1,0,0,0,16'h0,0,1, 1,2'b00,4'hF, 4'b1110,16'h0,4));
      // taken branch while fetch outstanding: deferred redirect
      tbl.push_back(mk(0,0,0,0,1,16'h3000,0,1, 0,2'b00,4'hF, 4'b0001,16'h3000,5));
      tbl.push_back(mk(0,0,0,0,0,16'h0,0,1, 0,2'b00,4'hF, 4'b0000,16'h3000,6));
      tbl.push_back(mk(0,0,0,0,0,16'h0,0,1, 0,2'b00,4'hF, 4'b0000,16'h3000,7));
      tbl.push_back(mk(0,1,0,0,0,16'h0,0,1, 1,2'b10,4'hF, 4'b0000,16'h3000,7));
      tbl.push_back(mk(0,1,0,0,0,16'h0,0,1, 1,2'b00,4'hF, 4'b1000,16'h3000,7));
      tbl.push_back(mk(0,1,0,0,0,16'h0,0,1, 1,2'b00,4'hF, 4'b1100,16'h3000,7));
      tbl.push_back(mk(0,1,0,0,0,16'h0,0,1, 1,2'b00,4'hF, 4'b1110,16'h3000,7));
      // enter WAIT again, then reset mid-WAIT
      tbl.push_back(mk(0,0,0,0,1,16'h1234,0,1, 0,2'b00,4'hF, 4'b0001,16'h1234,8));
      tbl.push_back(mk(1,0,0,0,0,16'h0,0,0, 0,2'b00,4'h0, 4'b0000,16'h0,0));
      tbl.push_back(mk(0,1,0,0,0,16'h0,0,1, 1,2'b00,4'hF, 4'b1000,16'h0,0));

      foreach (tbl[i]) apply(tbl[i], $sformatf("vec%0d", i));

      mv = 4'b0000; m_wait = 1'b0; m_redir = 16'h0; m_cnt = 0;
      for (int i = 0; i < 2000; i++) begin
         r.rst   = (i == 0) || ($urandom_range(0, 63) == 0);
         r.iresp = ($urandom_range(0, 9) < 6);
         r.dreq  = ($urandom_range(0, 2) == 0);
         r.dresp = $urandom_range(0, 1) == 1;
         r.br    = !m_wait && ($urandom_range(0, 4) == 0);
         r.tgt   = 16'($urandom);
         r.exrd  = $urandom_range(0, 1) == 1;
         r.dest  = 3'($urandom_range(0, 3));
         r.s1    = 3'($urandom_range(0, 3));
         r.s2    = 3'($urandom_range(0, 3));
         r.u1    = $urandom_range(0, 1) == 1;
         r.u2    = $urandom_range(0, 1) == 1;
         r.chk_comb = !r.rst;

         match = (r.u1 && r.s1 == r.dest) || (r.u2 && r.s2 == r.dest);
         dst = mv[1] && r.dreq && !r.dresp;
         fl  = mv[1] && r.br;
         hz  = mv[3] && mv[2] && r.exrd && match;
         r.lpc = 1'b0; r.sel = 2'b00; r.ld = 4'h0; r.v = mv; r.rd = m_redir;
         if (dst) begin
            r.v = mv;
         end else if (fl) begin
            r.ld = 4'hF;
            r.v  = 4'b0001;
            if (r.iresp) begin
               r.lpc = 1'b1; r.sel = 2'b01;
            end else begin
               r.rd = r.tgt;
            end
         end else if (hz) begin
            r.ld = 4'b0111;
            r.v  = {mv[3], 1'b0, mv[2], mv[1]};
         end else begin
            r.ld = 4'hF;
            r.v  = {r.iresp && !m_wait, mv[3], mv[2], mv[1]};
            if (r.iresp) begin
               r.lpc = 1'b1; r.sel = m_wait ? 2'b10 : 2'b00;
            end
         end
         if (r.rst) begin
            r.v = 4'b0000; r.rd = 16'h0; r.cnt = 0;
         end else begin
            r.cnt = r.lpc ? m_cnt : ((m_cnt + 1 > 15) ? 15 : m_cnt + 1);
         end

         apply(r, $sformatf("rand%0d", i));

         if (r.rst)
            m_wait = 1'b0;
         else if (!dst && fl && !r.iresp)
            m_wait = 1'b1;
         else if (!dst && !fl && !hz && r.iresp)
            m_wait = 1'b0;
         mv = r.v; m_redir = r.rd; m_cnt = r.cnt;
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
